// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte, FSM encodings
// and the baud divider calculation.
package uart_program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Rounded integer clock cycles per serial bit.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_program_loader_rx_byte.sv
// UART byte receiver: 2-FF synchronizer, mid-bit sampling, glitch rejection,
// one-cycle byte_valid / frame_err pulses registered after the stop-bit sample.
module uart_rx_byte
    import uart_program_loader_pkg::*;
#(
    parameter int BAUD_DIV = 139
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W    = $clog2(BAUD_DIV + 1);
    localparam int HALF_DIV = BAUD_DIV / 2;

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Frame-level program loader: parses SYNC/COUNT/DATA/CSUM frames from the UART
// receiver, writes 32-bit words to program RAM and gates the CPU via cpu_hold.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_HZ      = 16000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT_CYC = 160000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RX,
    output logic              cpu_hold,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              load_done,
    output logic              load_err
);

    localparam int          BAUD_DIV  = baud_div(CLK_HZ, BAUD);
    localparam int          TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int          WL_W      = ADDR_W + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk        (CLK),
        .rst_n      (RST_N),
        .rx         (RX),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    ld_state_e         state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        sum_q, sum_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_err_q, load_err_d;
    logic              load_done_q, load_done_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;

    logic [15:0]       n_words;
    logic [7:0]        sum_next;
    logic              err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            cnt_hi_q     <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            sum_q        <= '0;
            timeout_q    <= '0;
            cpu_hold_q   <= 1'b0;
            load_err_q   <= 1'b0;
            load_done_q  <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            sum_q        <= sum_d;
            timeout_q    <= timeout_d;
            cpu_hold_q   <= cpu_hold_d;
            load_err_q   <= load_err_d;
            load_done_q  <= load_done_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        sum_d        = sum_q;
        timeout_d    = timeout_q;
        cpu_hold_d   = cpu_hold_q;
        load_err_d   = load_err_q;
        load_done_d  = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        err          = 1'b0;
        n_words      = {cnt_hi_q, rx_byte};
        sum_next     = sum_q + rx_byte;

        // Address advances the cycle after each write strobe.
        if (ram_we_q) begin
            ram_addr_d = ram_addr_q + 1'b1;
        end

        if (state_q == ST_IDLE) begin
            if (byte_valid && rx_byte == SYNC_BYTE) begin
                state_d    = ST_CNT_HI;
                cpu_hold_d = 1'b1;
                load_err_d = 1'b0;
                sum_d      = '0;
                ram_addr_d = '0;
                timeout_d  = '0;
            end
        end else if (frame_err) begin
            err = 1'b1;
        end else if (byte_valid) begin
            timeout_d = '0;
            sum_d     = sum_next;
            case (state_q)
                ST_CNT_HI: begin
                    cnt_hi_d = rx_byte;
                    state_d  = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    if (n_words == 16'd0 || {1'b0, n_words} > MAX_WORDS) begin
                        err = 1'b1;
                    end else begin
                        words_left_d = WL_W'(n_words);
                        byte_idx_d   = '0;
                        state_d      = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Big-endian assembly: the first byte ends up in bits 31:24.
                    byte_idx_d = byte_idx_q + 1'b1;
                    asm_d      = {asm_q[15:0], rx_byte};
                    if (byte_idx_q == 2'd3) begin
                        ram_we_d     = 1'b1;
                        ram_wdata_d  = {asm_q, rx_byte};
                        words_left_d = words_left_q - 1'b1;
                        if (words_left_q == WL_W'(1)) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (sum_next == 8'h00) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_q == TO_W'(TIMEOUT_CYC)) begin
            err = 1'b1;
        end else begin
            timeout_d = timeout_q + 1'b1;
        end

        if (err) begin
            load_err_d = 1'b1;
            cpu_hold_d = 1'b1;
            state_d    = ST_IDLE;
        end
    end

    assign cpu_hold  = cpu_hold_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: serialises frames onto RX and
// compares RAM writes, load_done and status flags against a frame-level model.
module tb_uart_program_loader;

    localparam int CLK_HZ      = 1_600_000;
    localparam int BAUD        = 100_000;
    localparam int ADDR_W      = 11;
    localparam int TIMEOUT_CYC = 2000;
    localparam int BIT_CYC     = 16;

    localparam int MODE_GOOD    = 0;
    localparam int MODE_BADSUM  = 1;
    localparam int MODE_TRUNC   = 2;
    localparam int MODE_BADSTOP = 3;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx    = 1'b1;
    logic              cpu_hold;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              load_done;
    logic              load_err;

    uart_program_loader #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .RX        (rx),
        .cpu_hold  (cpu_hold),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int                checks    = 0;
    int                errors    = 0;
    int                exp_done  = 0;
    int                done_seen = 0;
    wr_t               exp_wr[$];
    logic [31:0]       cap_data[$];
    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       wbuf[0:7];
    logic [7:0]        last_csum;

    wr_t               cmp_w;
    logic              prev_we   = 1'b0;
    logic              prev_hold = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [ADDR_W-1:0] next_addr;

    // Cycle-by-cycle comparison of write strobes and done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (ram_we) begin
                checks++;
                cap_data.push_back(ram_wdata);
                cap_addr.push_back(ram_addr);
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL write_unexpected got addr=%0d data=%08h want no write", ram_addr, ram_wdata);
                end else begin
                    cmp_w = exp_wr.pop_front();
                    if (ram_addr !== cmp_w.addr || ram_wdata !== cmp_w.data) begin
                        errors++;
                        $display("[TB] FAIL write_value got addr=%0d data=%08h want addr=%0d data=%08h",
                                 ram_addr, ram_wdata, cmp_w.addr, cmp_w.data);
                    end
                end
            end
            if (prev_we) begin
                checks++;
                next_addr = prev_addr + 1'b1;
                if (ram_we !== 1'b0 || ram_addr !== next_addr) begin
                    errors++;
                    $display("[TB] FAIL addr_step got we=%0b addr=%0d want we=0 addr=%0d", ram_we, ram_addr, next_addr);
                end
            end
            if (load_done) begin
                checks++;
                done_seen++;
                if (exp_done == 0 || exp_wr.size() != 0 || cpu_hold !== 1'b0 || prev_hold !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL load_done got hold=%0b prev_hold=%0b pending_done=%0d pending_wr=%0d want hold=0 prev_hold=1 pending_done>0 pending_wr=0",
                             cpu_hold, prev_hold, exp_done, exp_wr.size());
                end
                if (exp_done > 0) exp_done--;
            end
            prev_we   = ram_we;
            prev_addr = ram_addr;
            prev_hold = cpu_hold;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (BIT_CYC) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(posedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (BIT_CYC) @(posedge clk);
        rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // Sends one frame and records, from the frame rules alone, which writes,
    // done pulse and final flags it must produce.
    task automatic applyStimulus(input int cnt, input int mode, input int fault,
                                 output logic exp_hold, output logic exp_err);
        logic [7:0] sum;
        logic [7:0] b;
        int         nbytes;
        int         nwords;
        bit         cnt_ok;
        bit         bad;
        wr_t        w;
        cnt_ok   = (cnt >= 1) && (cnt <= (1 << ADDR_W));
        exp_hold = !(cnt_ok && mode == MODE_GOOD);
        exp_err  = exp_hold;
        if (cnt_ok) begin
            nwords = (mode == MODE_TRUNC || mode == MODE_BADSTOP) ? fault / 4 : cnt;
            for (int i = 0; i < nwords; i++) begin
                w.addr = ADDR_W'(i);
                w.data = wbuf[i];
                exp_wr.push_back(w);
            end
            if (mode == MODE_GOOD) exp_done++;
        end
        sum = 8'(cnt >> 8) + 8'(cnt);
        send_byte(8'hA5, 1'b0);
        send_byte(8'(cnt >> 8), 1'b0);
        send_byte(8'(cnt), 1'b0);
        if (cnt_ok) begin
            nbytes = (mode == MODE_TRUNC) ? fault : cnt * 4;
            for (int k = 0; k < nbytes; k++) begin
                b   = 8'(wbuf[k / 4] >> (8 * (3 - (k % 4))));
                sum = sum + b;
                bad = (mode == MODE_BADSTOP) && (k == fault);
                send_byte(b, bad);
                if (bad) break;
            end
            if (mode == MODE_GOOD || mode == MODE_BADSUM) begin
                last_csum = (mode == MODE_GOOD) ? 8'(8'h00 - sum) : 8'(8'h01 - sum);
                send_byte(last_csum, 1'b0);
            end
            if (mode == MODE_TRUNC) repeat (TIMEOUT_CYC + 300) @(posedge clk);
        end
    endtask

    task automatic checkOutput(input string name, input logic exp_hold, input logic exp_err);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_done != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_wr.size() != 0 || exp_done != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain got pending_wr=%0d pending_done=%0d want 0 and 0", name, exp_wr.size(), exp_done);
            exp_wr.delete();
            exp_done = 0;
        end
        @(negedge clk);
        checks++;
        if (cpu_hold !== exp_hold) begin
            errors++;
            $display("[TB] FAIL %s_hold got %0b want %0b", name, cpu_hold, exp_hold);
        end
        checks++;
        if (load_err !== exp_err) begin
            errors++;
            $display("[TB] FAIL %s_err got %0b want %0b", name, load_err, exp_err);
        end
    endtask

    task automatic checkReset(input string name);
        checks++;
        if (cpu_hold !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== 32'h0 ||
            load_done !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s got hold=%0b we=%0b addr=%0d wdata=%08h done=%0b err=%0b want all 0",
                     name, cpu_hold, ram_we, ram_addr, ram_wdata, load_done, load_err);
        end
    endtask

    initial begin
        logic eh;
        logic ee;
        int   ncap;
        int   n;
        int   m;
        int   f;
        logic [7:0] junk;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkReset("reset_asserted");
        rst_n = 1'b1;
        repeat (3000) @(posedge clk);
        @(negedge clk);
        checkReset("idle_after_reset");

        $display("[TB] reference frame");
        wbuf[0] = 32'h20000001;
        wbuf[1] = 32'h30000000;
        cap_data.delete();
        cap_addr.delete();
        applyStimulus(2, MODE_GOOD, 0, eh, ee);
        checkOutput("ref_frame", eh, ee);
        checks++;
        if (last_csum !== 8'hAD) begin
            errors++;
            $display("[TB] FAIL ref_csum got %02h want AD", last_csum);
        end
        checks++;
        if (cap_data.size() != 2 || cap_data[0] !== 32'h20000001 || cap_addr[0] !== 0 ||
            cap_data[1] !== 32'h30000000 || cap_addr[1] !== 1) begin
            errors++;
            $display("[TB] FAIL ref_writes got count=%0d w0=%08h@%0d w1=%08h@%0d want 2 20000001@0 30000000@1",
                     cap_data.size(), cap_data[0], cap_addr[0], cap_data[1], cap_addr[1]);
        end
        checks++;
        if (done_seen != 1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ref_done got pulses=%0d hold=%0b want 1 and 0", done_seen, cpu_hold);
        end

        $display("[TB] bad checksum then recovery");
        ncap = cap_data.size();
        applyStimulus(2, MODE_BADSUM, 0, eh, ee);
        checkOutput("bad_csum", eh, ee);
        checks++;
        if (cap_data.size() != ncap + 2 || load_err !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_csum_pin got writes=%0d err=%0b hold=%0b want 2 1 1",
                     cap_data.size() - ncap, load_err, cpu_hold);
        end
        applyStimulus(2, MODE_GOOD, 0, eh, ee);
        checkOutput("recover", eh, ee);

        $display("[TB] timeout inside frame");
        wbuf[0] = 32'h12345678;
        ncap = cap_data.size();
        applyStimulus(1, MODE_TRUNC, 2, eh, ee);
        checkOutput("timeout", eh, ee);
        checks++;
        if (cap_data.size() != ncap || load_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_pin got writes=%0d err=%0b want 0 1", cap_data.size() - ncap, load_err);
        end

        $display("[TB] framing error and bad counts");
        wbuf[0] = 32'hDEADBEEF;
        wbuf[1] = 32'hA5A5A5A5;
        wbuf[2] = 32'h01020304;
        applyStimulus(3, MODE_BADSTOP, 5, eh, ee);
        checkOutput("bad_stop", eh, ee);
        applyStimulus(1, MODE_GOOD, 0, eh, ee);
        checkOutput("good_one_a", eh, ee);
        ncap = cap_data.size();
        applyStimulus(0, MODE_GOOD, 0, eh, ee);
        checkOutput("count_zero", eh, ee);
        applyStimulus(1, MODE_GOOD, 0, eh, ee);
        checkOutput("good_one_b", eh, ee);
        applyStimulus(16'h0801, MODE_GOOD, 0, eh, ee);
        checkOutput("count_big", eh, ee);
        checks++;
        if (cap_data.size() != ncap + 1) begin
            errors++;
            $display("[TB] FAIL bad_count_writes got %0d want 1", cap_data.size() - ncap);
        end

        $display("[TB] reset in the middle of data");
        wbuf[0] = 32'hCAFEF00D;
        wbuf[1] = 32'h11223344;
        cmp_w.addr = '0;
        cmp_w.data = wbuf[0];
        exp_wr.push_back(cmp_w);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send_byte(8'(wbuf[k / 4] >> (8 * (3 - (k % 4)))), 1'b0);
        end
        checkOutput("mid_frame", 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkReset("reset_mid_frame");
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        wbuf[0] = 32'h0BADC0DE;
        wbuf[1] = 32'h55AA55AA;
        wbuf[2] = 32'h00000000;
        applyStimulus(3, MODE_GOOD, 0, eh, ee);
        checkOutput("after_reset", eh, ee);

        $display("[TB] randomized frames");
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                wbuf[i] = ($urandom_range(0, 3) == 0) ? 32'hA5A5A5A5 : $urandom;
            end
            m = $urandom_range(0, 5);
            m = (m <= 2) ? MODE_GOOD : (m == 3) ? MODE_BADSUM : (m == 4) ? MODE_BADSTOP : MODE_TRUNC;
            f = $urandom_range(0, n * 4 - 1);
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk, 1'($urandom_range(0, 1)));
            applyStimulus(n, m, f, eh, ee);
            checkOutput("random_frame", eh, ee);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #950_000;
        errors++;
        $display("[TB] FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Serial program loader that receives a framed instruction image over a UART line and writes it, one 32-bit word per RAM write, into the CPU's program RAM. It is the writer side of the CPU's instruction fetch path: while a load is in progress it holds the CPU off, and it releases the CPU to run from address 0 only after a frame passes its checksum. Sits between the board RX pin and the program-RAM write port, alongside the CPU core.

## Interface
- CLK_HZ, 16000000: input clock frequency.
- BAUD, 115200: serial bit rate; BAUD_DIV = round(CLK_HZ/BAUD) (139 at defaults).
- ADDR_W, 11: program RAM address width; maximum image is 2^ADDR_W words.
- TIMEOUT_CYC, 160000: maximum idle cycles between bytes inside a frame (10 ms at 16 MHz).

- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- RX  in  1  UART serial input, idle high, asynchronous to CLK.
- cpu_hold  out  1  high while a frame is being received or after a failed frame; CPU holds pc=0 and does not fetch.
- ram_we  out  1  single-cycle write strobe.
- ram_addr  out  ADDR_W  word write address.
- ram_wdata  out  32  word write data.
- load_done  out  1  one-cycle pulse on successful frame.
- load_err  out  1  sticky error flag; cleared on next sync byte.

## Operation
- Frame: SYNC 0xA5, COUNT_HI, COUNT_LO (N words), N×4 data bytes big-endian (first byte = bits 31:24), CSUM. Valid iff 8-bit sum of all bytes after SYNC, including CSUM, is 0x00.
- Byte receiver: RX through 2-FF synchronizer; falling edge starts; re-sample at BAUD_DIV/2, abort silently if high (glitch); 8 data bits LSB-first each BAUD_DIV later; stop bit sampled; stop=0 is a framing error.
- States: IDLE, CNT_HI, CNT_LO, DATA, CSUM.
  - IDLE: byte 0xA5 -> CNT_HI, cpu_hold<=1, load_err<=0, sum<=0, ram_addr<=0. Other bytes ignored.
  - CNT_HI -> CNT_LO -> DATA. After CNT_LO, N=0 or N>2^ADDR_W is an error.
  - DATA: shift bytes into 32-bit assembler; on 4th byte issue write at ram_addr, then increment ram_addr; after N words -> CSUM.
  - CSUM: sum==0 -> load_done pulse, cpu_hold<=0, IDLE. Else error.
- Error (bad count, bad checksum, framing error in frame, timeout): load_err<=1, cpu_hold stays 1, -> IDLE. Words already written remain in RAM; CPU stays held until a good frame.
- Framing error or SYNC in IDLE outside a frame: ignored, no flag.
- 0xA5 inside a frame is data, not resync.

## Timing
- Reset values: cpu_hold 0, ram_we 0, ram_addr 0, ram_wdata 0, load_done 0, load_err 0; FSM IDLE. CPU runs its initial RAM image if no frame arrives.
- Reset mid-frame: all outputs return to reset values immediately; partial image stays in RAM.
- Byte valid asserts one cycle after stop-bit sample. ram_we, ram_addr, ram_wdata valid together on the cycle after 4th data-byte valid; ram_addr increments the cycle after ram_we.
- load_done and cpu_hold falling edge in the same cycle, one cycle after CSUM byte valid.
- Timeout counter resets on each byte valid, runs only outside IDLE; error on count == TIMEOUT_CYC.
- Sum is 8-bit wrap-around.

## Structure
- Shared package: SYNC_BYTE (0xA5), FSM state encoding, BAUD_DIV computation.
- Sub-module uart_rx_byte: synchronizer, bit timing, outputs byte[7:0], byte_valid pulse, frame_err pulse. Top holds frame FSM, word assembler, checksum, timeout.

## Test plan
- Reset then RX idle 1 ms -> all outputs stay at reset values, no ram_we.
- Frame A5 00 02 20 00 00 01 30 00 00 00 CSUM=0xAD -> writes 0x20000001@0, 0x30000000@1, one load_done pulse, cpu_hold 1->0.
- Same frame with CSUM=0xAC -> two writes, load_err=1, cpu_hold=1; following good frame clears load_err and drops cpu_hold.
- A5 00 01 12 34 then silence > TIMEOUT_CYC -> no write, load_err=1, FSM IDLE.
- Stop bit forced 0 on a data byte -> load_err=1; COUNT 00 00 and COUNT 08 01 (ADDR_W=11) -> load_err=1, no writes.
- RST_N low mid-DATA -> outputs at reset values within same cycle; subsequent good frame loads from address 0.
